fir_fifo_wr_arbiter: RTL

//  Round-robin burst arbiter that shares the single write port of the FIR accelerator's

---
 rtl/fir_accel_pkg.sv | 29 ++
 rtl/fir_fifo_wr_arbiter_if.sv | 34 +++
 rtl/fir_rr_pick.sv | 37 +++
 rtl/fir_fifo_wr_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fir_accel_pkg.sv
// Shared FIR accelerator definitions: arbiter state encoding, width helpers and
// the statistics counter width.
package fir_accel_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index width for n producers; a single-bit index is the floor.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fir_fifo_wr_arbiter_if.sv
// Producer valid/ready bundle plus the fifo_sync write-side signals shared by the
// write arbiter (master) and its surroundings (slave).
interface fir_fifo_wr_arbiter_if
  import fir_accel_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int PTR_W   = 4
) ();

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic                     fifo_full;
  logic [PTR_W:0]           fifo_level;
  logic                     grant_valid;
  logic [ID_W-1:0]          grant_id;

  modport master (
    input  req_valid, req_last, req_data, fifo_full, fifo_level,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full, fifo_level,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );

endinterface

// File: rtl/fir_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or above ptr,
// wrapping at NUM_REQ. Shared with the FIR read-side schedulers.
module fir_rr_pick
  import fir_accel_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]           req,
  input  logic [id_width(NUM_REQ)-1:0] ptr,
  output logic                         any,
  output logic [id_width(NUM_REQ)-1:0] sel
);

  localparam int ID_W = id_width(NUM_REQ);

  logic found;
  int   idx;

  // NOTE: every variable written here gets a default first, so no path leaves a
  // value held over from a previous evaluation (which would infer a latch).
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fir_fifo_wr_arbiter.sv
// Round-robin burst arbiter for the single fifo_sync write port. A grant is only
// issued when the FIFO can absorb a full burst. Define FIR_ARB_STATS_EN for
// per-producer beat counters readable through stat_sel/stat_beats.
module fir_fifo_wr_arbiter
  import fir_accel_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int PTR_W     = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  fir_fifo_wr_arbiter_if.master        bus
`ifdef FIR_ARB_STATS_EN
  ,
  input  logic [id_width(NUM_REQ)-1:0] stat_sel,
  input  logic                         stat_clr,
  output logic [STAT_W-1:0]            stat_beats
`endif
);

  localparam int                ID_W          = id_width(NUM_REQ);
  localparam int                BCNT_W        = clog2(BURST_MAX + 1);
  localparam int                LVL_W         = PTR_W + 1;
  localparam logic [LVL_W-1:0]  LVL_GRANT_MAX = LVL_W'(DEPTH - BURST_MAX);
  localparam logic [BCNT_W-1:0] BCNT_LAST     = BCNT_W'(BURST_MAX - 1);
  localparam logic [ID_W-1:0]   ID_LAST       = ID_W'(NUM_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic              pick_any;
  logic [ID_W-1:0]   pick_sel;
  logic              room;
  logic              in_burst;
  logic              g_valid;
  logic              g_last;
  logic              beat;
  logic              burst_end;
  logic [WIDTH-1:0]  g_data;
  logic [ID_W-1:0]   next_ptr;

  fir_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .sel (pick_sel)
  );

  // Room for a whole burst: DEPTH - level >= BURST_MAX, written without subtraction wrap.
  assign room     = (bus.fifo_level <= LVL_GRANT_MAX);
  assign in_burst = (state_q == ARB_BURST);
  assign g_valid  = bus.req_valid[grant_id_q];
  assign g_last   = bus.req_last[grant_id_q];
  assign beat     = in_burst && g_valid && !bus.fifo_full;
  assign next_ptr = (grant_id_q == ID_LAST) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) g_data = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    burst_end  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any && room) begin
          state_d    = ARB_BURST;
          grant_id_d = pick_sel;
          beat_cnt_d = '0;
        end
      end
      ARB_BURST: begin
        // A full FIFO only stalls; a dropped valid ends the burst without a beat.
        if (!g_valid) begin
          burst_end = 1'b1;
        end else if (beat) begin
          if (beat_cnt_q == BCNT_LAST || g_last) burst_end = 1'b1;
          else                                   beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (burst_end) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Write path is a zero-latency pass-through of the grantee; everything is forced
  // quiet while rst is high.
  always_comb begin
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    if (!rst) begin
      if (in_burst && !bus.fifo_full) bus.req_ready[grant_id_q] = 1'b1;
      if (beat) begin
        bus.fifo_wr_en   = 1'b1;
        bus.fifo_wr_data = g_data;
      end
    end
  end

  assign bus.grant_valid = in_burst && !rst;
  assign bus.grant_id    = rst ? '0 : grant_id_q;

`ifdef FIR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt_q [NUM_REQ];
  logic [STAT_W-1:0] stat_cnt_d [NUM_REQ];
  logic [STAT_W-1:0] stat_beats_q, stat_beats_d;

  // Clear wins over a coincident beat; counters stick at all-ones.
  always_comb begin
    stat_beats_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_cnt_d[i] = stat_cnt_q[i];
      if (stat_sel == ID_W'(i)) stat_beats_d = stat_cnt_q[i];
      if (stat_clr) begin
        stat_cnt_d[i] = '0;
      end else if (beat && grant_id_q == ID_W'(i) && stat_cnt_q[i] != '1) begin
        stat_cnt_d[i] = stat_cnt_q[i] + 1'b1;
      end
    end
  end

  // NOTE: this counter array is reset explicitly because software reads it right
  // after reset; plain storage arrays elsewhere would be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt_q[i] <= '0;
      stat_beats_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt_q[i] <= stat_cnt_d[i];
      stat_beats_q <= stat_beats_d;
    end
  end

  assign stat_beats = rst ? '0 : stat_beats_q;
`endif

endmodule
